// File: rtl/fifo_word_reader_pkg.sv
// Shared types and constants for the FIFO word reader: FSM states,
// default geometry and the lane keep-mask helper.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        LAST = 2'd2,
        OUT  = 2'd3
    } rd_state_t;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PACK       = 4;
    localparam int DEF_THRESH     = 4;
    localparam int MAX_PACK       = 8;

    // Lower 'cnt' lanes set; callers cast down to their own PACK width.
    function automatic logic [MAX_PACK-1:0] keep_mask(input logic [3:0] cnt);
        logic [MAX_PACK:0] w_one;
        w_one = (MAX_PACK+1)'(1) << cnt;
        return MAX_PACK'(w_one - (MAX_PACK+1)'(1));
    endfunction

endpackage

// File: rtl/fifo_word_reader_if.sv
// FIFO-side get/data/fillcount signals plus the packed output stream.
// master = the reader, slave = the FIFO/downstream side.
interface fifo_word_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PACK       = DEF_PACK
) ();
    logic                    fifo_get;
    logic [WIDTH-1:0]        fifo_data;
    logic [ADDR_WIDTH:0]     fifo_fillcount;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [PACK*WIDTH-1:0]   out_data;
    logic [PACK-1:0]         out_keep;
    logic                    busy;

    modport master (
        output fifo_get, out_valid, out_data, out_keep, busy,
        input  fifo_data, fifo_fillcount, flush, out_ready
    );

    modport slave (
        input  fifo_get, out_valid, out_data, out_keep, busy,
        output fifo_data, fifo_fillcount, flush, out_ready
    );
endinterface

// File: rtl/fifo_word_reader_lane_packer.sv
// Lane register array: writes one entry into lane i_idx when i_we is high.
// Unwritten lanes stay zero until the word is cleared.
module lane_packer
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK,
    parameter int CNT_W = $clog2(DEF_PACK + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [CNT_W-1:0]      i_idx,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_clr,
    output logic [PACK*WIDTH-1:0] o_data
);
    logic [PACK-1:0][WIDTH-1:0] r_lane;

    // Clear wins over capture so an accepted word never leaks into the next.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_lane <= '0;
        end else if (i_we) begin
            for (int i = 0; i < PACK; i++) begin
                if (i_idx == CNT_W'(i)) r_lane[i] <= i_din;
            end
        end
    end

    assign o_data = r_lane;
endmodule

// File: rtl/fifo_word_reader.sv
// Consumer end of a single-clock FIFO: issues gets, absorbs the one-cycle
// read latency and packs PACK entries into one valid/ready output word.
// A flush request emits whatever has been gathered with a lane keep mask.
module fifo_word_reader
    import fifo_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PACK       = DEF_PACK,
    parameter int THRESH     = DEF_THRESH
) (
    input logic               clk,
    input logic               reset,
    fifo_word_reader_if.master bus
);
    localparam int                  CNT_W    = $clog2(PACK + 1);
    localparam logic [CNT_W:0]      PACK_C   = (CNT_W+1)'(PACK);
    localparam logic [ADDR_WIDTH:0] THRESH_C = (ADDR_WIDTH+1)'(THRESH);

    rd_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_flush_req;

    logic             w_fifo_nempty;
    logic [CNT_W:0]   w_inflight;
    logic             w_get;
    logic             w_start;
    logic             w_clr;
    logic             w_flush_clr;
    logic [PACK-1:0]  w_keep;

    // Fillcount already accounts for gets in flight, so only our own
    // captured + pending entries limit further fetching.
    assign w_fifo_nempty = (bus.fifo_fillcount != '0);
    assign w_inflight    = {1'b0, r_cnt} + (CNT_W+1)'(r_pending);
    assign w_get         = (r_state == FILL) && (w_inflight < PACK_C) && w_fifo_nempty;
    assign w_start       = (bus.fifo_fillcount >= THRESH_C) || (r_flush_req && w_fifo_nempty);

    // Next-state and word-control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_flush_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = FILL;
                end else if (r_flush_req && (r_cnt == '0)) begin
                    // Flush with nothing buffered and nothing to fetch.
                    w_flush_clr = 1'b1;
                end
            end
            FILL: begin
                if (w_get && ((w_inflight + (CNT_W+1)'(1)) == PACK_C)) begin
                    w_state_nxt = LAST;
                end else if (r_flush_req && !w_fifo_nempty && !w_get) begin
                    w_state_nxt = LAST;
                end
            end
            LAST: begin
                // Wait until the final read has landed in its lane.
                if (!r_pending) begin
                    if (r_cnt != '0) begin
                        w_state_nxt = OUT;
                    end else begin
                        w_state_nxt = IDLE;
                        w_flush_clr = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_flush_clr = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Lane counter, read-latency tracker and sticky flush request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_flush_req <= 1'b0;
        end else begin
            r_pending <= w_get;
            if (w_clr)          r_cnt <= '0;
            else if (r_pending) r_cnt <= r_cnt + CNT_W'(1);
            // A new pulse beats the clear so it applies to the next word.
            if (bus.flush)        r_flush_req <= 1'b1;
            else if (w_flush_clr) r_flush_req <= 1'b0;
        end
    end

    lane_packer #(
        .WIDTH (WIDTH),
        .PACK  (PACK),
        .CNT_W (CNT_W)
    ) u_lanes (
        .clk    (clk),
        .reset  (reset),
        .i_we   (r_pending),
        .i_idx  (r_cnt),
        .i_din  (bus.fifo_data),
        .i_clr  (w_clr),
        .o_data (bus.out_data)
    );

    assign w_keep        = PACK'(keep_mask(4'(r_cnt)));
    assign bus.fifo_get  = w_get;
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_keep  = (r_state == OUT) ? w_keep : '0;
    assign bus.busy      = (r_state != IDLE) || r_flush_req;
endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader with a behavioural single-clock FIFO
// (registered read, combinational fillcount). THRESH is set to 3 so a
// word can start with fewer than PACK entries and starve mid-word.
module tb_fifo_word_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       put_en;
    logic [7:0] put_data;

    fifo_word_reader_if #(.ADDR_WIDTH(4), .WIDTH(8), .PACK(4)) bus ();

    fifo_word_reader #(.ADDR_WIDTH(4), .WIDTH(8), .PACK(4), .THRESH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural FIFO
    logic [7:0] mem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic [7:0] rd_q;
    int         n_get = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always @(posedge clk) begin
        if (reset) begin
            wp <= '0; rp <= '0; fcnt <= '0; rd_q <= '0;
        end else begin
            if (put_en) begin
                mem[wp] <= put_data;
                wp      <= wp + 4'd1;
            end
            if (bus.fifo_get) begin
                rd_q <= mem[rp];
                rp   <= rp + 4'd1;
            end
            fcnt <= fcnt + 5'(put_en) - 5'(bus.fifo_get);
        end
        if (bus.fifo_get) n_get <= n_get + 1;
    end

    assign bus.fifo_data      = rd_q;
    assign bus.fifo_fillcount = fcnt;

    task automatic do_reset();
        reset = 1'b1; put_en = 1'b0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic put1(input logic [7:0] d);
        put_en = 1'b1; put_data = d;
        @(negedge clk);
        put_en = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        for (int i = 0; i < lim && !bus.out_valid; i++) @(negedge clk);
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.out_valid, bus.fifo_get, bus.busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000", {bus.out_valid, bus.fifo_get, bus.busy});
        end
        n_cmp++;
        if (bus.out_data !== 32'h0 || bus.out_keep !== 4'h0) begin
            n_err++; $display("FAIL reset_word: got %h/%b want 0/0", bus.out_data, bus.out_keep);
        end
    endtask

    task automatic test_full_word();
        int g0, first, vcyc;
        do_reset();
        bus.out_ready = 1'b1;
        g0 = n_get;
        put1(8'h11); put1(8'h22); put1(8'h33); put1(8'h44);
        first = -1; vcyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (bus.fifo_get && first < 0) first = c;
            if (bus.out_valid) begin vcyc = c; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (vcyc < 0 || first < 0 || (vcyc - first) != 6) begin
            n_err++; $display("FAIL full_latency: got first=%0d valid=%0d want valid-first=6", first, vcyc);
        end
        n_cmp++;
        if (bus.out_data !== 32'h44332211) begin
            n_err++; $display("FAIL full_data: got %h want 44332211", bus.out_data);
        end
        n_cmp++;
        if (bus.out_keep !== 4'b1111) begin
            n_err++; $display("FAIL full_keep: got %b want 1111", bus.out_keep);
        end
        n_cmp++;
        if (n_get - g0 != 4 || fcnt !== 5'd0) begin
            n_err++; $display("FAIL full_gets: got gets=%0d fill=%0d want 4/0", n_get - g0, fcnt);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL full_accept: got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_below_thresh();
        int g0; bit busy_get, ok;
        do_reset();
        bus.out_ready = 1'b1;
        g0 = n_get;
        put1(8'hAA); put1(8'hBB);
        busy_get = 1'b0;
        repeat (20) begin
            if (bus.fifo_get || bus.out_valid) busy_get = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (busy_get || n_get != g0) begin
            n_err++; $display("FAIL below_idle: got activity=%b gets=%0d want 0/0", busy_get, n_get - g0);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || bus.out_data !== 32'h0000BBAA) begin
            n_err++; $display("FAIL below_flush_data: got valid=%b data=%h want 1/0000bbaa", ok, bus.out_data);
        end
        n_cmp++;
        if (bus.out_keep !== 4'b0011) begin
            n_err++; $display("FAIL below_flush_keep: got %b want 0011", bus.out_keep);
        end
    endtask

    task automatic test_backpressure();
        int g0, g1; bit ok, stable;
        do_reset();
        bus.out_ready = 1'b0;
        g0 = n_get;
        for (int i = 1; i <= 8; i++) put1(8'(i));
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF) begin
            n_err++; $display("FAIL bp_word1: got valid=%b data=%h keep=%b want 1/04030201/1111", ok, bus.out_data, bus.out_keep);
        end
        g1 = n_get;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF || bus.fifo_get) stable = 1'b0;
        end
        n_cmp++;
        if (!stable || n_get != g1 || g1 - g0 != 4) begin
            n_err++; $display("FAIL bp_hold: got stable=%b gets=%0d want 1/4", stable, n_get - g0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || bus.out_data !== 32'h08070605 || bus.out_keep !== 4'hF) begin
            n_err++; $display("FAIL bp_word2: got valid=%b data=%h keep=%b want 1/08070605/1111", ok, bus.out_data, bus.out_keep);
        end
        n_cmp++;
        if (n_get - g0 != 8) begin
            n_err++; $display("FAIL bp_gets: got %0d want 8", n_get - g0);
        end
    endtask

    task automatic test_starvation();
        int g0; bit late_get, ok;
        do_reset();
        bus.out_ready = 1'b1;
        g0 = n_get;
        put1(8'hA1); put1(8'hA2); put1(8'hA3);
        late_get = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (c >= 5 && (bus.fifo_get || bus.out_valid)) late_get = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (late_get || bus.busy !== 1'b1 || n_get - g0 != 3) begin
            n_err++; $display("FAIL starve_wait: got activity=%b busy=%b gets=%0d want 0/1/3", late_get, bus.busy, n_get - g0);
        end
        put1(8'hA4);
        wait_valid(20, ok);
        n_cmp++;
        if (!ok || bus.out_data !== 32'hA4A3A2A1 || bus.out_keep !== 4'hF) begin
            n_err++; $display("FAIL starve_word: got valid=%b data=%h keep=%b want 1/a4a3a2a1/1111", ok, bus.out_data, bus.out_keep);
        end
    endtask

    task automatic test_flush_empty();
        bit saw_valid;
        do_reset();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++; $display("FAIL fe_busy_set: got %b want 1", bus.busy);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL fe_busy_clr: got %b want 0", bus.busy);
        end
        saw_valid = 1'b0;
        repeat (5) begin
            if (bus.out_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (saw_valid) begin
            n_err++; $display("FAIL fe_no_word: got valid seen=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        int g0; bit ok;
        do_reset();
        bus.out_ready = 1'b1;
        g0 = n_get;
        put1(8'hC1); put1(8'hC2); put1(8'hC3);
        repeat (8) @(negedge clk);
        n_cmp++;
        if (n_get - g0 != 3 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL rm_pre: got gets=%0d busy=%b want 3/1", n_get - g0, bus.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.fifo_get, bus.busy} !== 3'b000 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0) begin
            n_err++; $display("FAIL rm_outputs: got ctl=%b data=%h keep=%b want 000/0/0",
                              {bus.out_valid, bus.fifo_get, bus.busy}, bus.out_data, bus.out_keep);
        end
        reset = 1'b0;
        put1(8'hD1); put1(8'hD2); put1(8'hD3); put1(8'hD4);
        wait_valid(30, ok);
        n_cmp++;
        if (!ok || bus.out_data !== 32'hD4D3D2D1 || bus.out_keep !== 4'hF) begin
            n_err++; $display("FAIL rm_word: got valid=%b data=%h keep=%b want 1/d4d3d2d1/1111", ok, bus.out_data, bus.out_keep);
        end
    endtask

    initial begin
        reset = 1'b1; put_en = 1'b0; put_data = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_below_thresh();
        test_backpressure();
        test_starvation();
        test_flush_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
